// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one 32-bit memory port between instruction fetch (IFU) and
//   load/store (LSU). Round-robin arbitration with at most one outstanding
//   transaction. Generates LSU byte enables and replicated write lanes, rejects
//   misaligned or illegal-size LSU requests locally, and ends a response wait
//   after RESP_TIMEOUT cycles with an error response.
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   ifu_req_i/addr_i         fetch request (always a word read)
//   ifu_gnt/rvalid/rdata/err fetch handshake and response
//   lsu_req/we/addr/size/wdata_i  load/store request
//   lsu_gnt/rvalid/rdata/err load/store handshake and response
//   mem_req/we/addr/be/wdata_o    memory request, held until mem_gnt_i
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i  memory handshake and response
//   busy_o                   high whenever a transaction is in progress
module mem_port_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned RESP_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ifu_req_i,
  input  logic [AW-1:0] ifu_addr_i,
  output logic          ifu_gnt_o,
  output logic          ifu_rvalid_o,
  output logic [31:0]   ifu_rdata_o,
  output logic          ifu_err_o,
  input  logic          lsu_req_i,
  input  logic          lsu_we_i,
  input  logic [AW-1:0] lsu_addr_i,
  input  logic [1:0]    lsu_size_i,
  input  logic [31:0]   lsu_wdata_i,
  output logic          lsu_gnt_o,
  output logic          lsu_rvalid_o,
  output logic [31:0]   lsu_rdata_o,
  output logic          lsu_err_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [3:0]    mem_be_o,
  output logic [31:0]   mem_wdata_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [31:0]   mem_rdata_i,
  output logic          busy_o
);

  localparam int unsigned CW = (RESP_TIMEOUT > 0) ? $clog2(RESP_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_VAL = CW'(RESP_TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_ERR} state_e;

  state_e        state_q, state_d;
  logic          last_lsu_q, last_lsu_d;
  logic          owner_lsu_q, owner_lsu_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [3:0]    lsu_be;
  logic [31:0]   lsu_wdata;
  logic          lsu_bad;
  logic          pick_lsu;
  logic          ifu_addr_unused;

  // Fetches are word aligned by contract; the low address bits carry no meaning.
  always_comb ifu_addr_unused = ^ifu_addr_i[1:0];

  // Lane placement and alignment check for the LSU request.
  always_comb begin
    lsu_be    = '0;
    lsu_wdata = lsu_wdata_i;
    lsu_bad   = 1'b0;
    case (lsu_size_i)
      2'b00: begin
        lsu_be    = 4'b0001 << lsu_addr_i[1:0];
        lsu_wdata = {4{lsu_wdata_i[7:0]}};
      end
      2'b01: begin
        lsu_be    = 4'b0011 << {lsu_addr_i[1], 1'b0};
        lsu_wdata = {2{lsu_wdata_i[15:0]}};
        lsu_bad   = lsu_addr_i[0];
      end
      2'b10: begin
        lsu_be  = 4'b1111;
        lsu_bad = |lsu_addr_i[1:0];
      end
      default: lsu_bad = 1'b1;
    endcase
  end

  // Outputs are forced low while rst is high so an in-flight transaction
  // cannot emit a response during the reset cycle itself.
  always_comb begin
    state_d      = state_q;
    last_lsu_d   = last_lsu_q;
    owner_lsu_d  = owner_lsu_q;
    we_d         = we_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    pick_lsu     = 1'b0;
    ifu_gnt_o    = 1'b0;
    ifu_rvalid_o = 1'b0;
    ifu_rdata_o  = '0;
    ifu_err_o    = 1'b0;
    lsu_gnt_o    = 1'b0;
    lsu_rvalid_o = 1'b0;
    lsu_rdata_o  = '0;
    lsu_err_o    = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_be_o     = '0;
    mem_wdata_o  = '0;
    busy_o       = 1'b0;
    if (!rst) begin
      busy_o = (state_q != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (ifu_req_i || lsu_req_i) begin
            // LSU wins a tie unless it won the previous arbitration.
            pick_lsu    = lsu_req_i && (!ifu_req_i || !last_lsu_q);
            owner_lsu_d = pick_lsu;
            last_lsu_d  = pick_lsu;
            if (pick_lsu) begin
              we_d    = lsu_we_i;
              addr_d  = {lsu_addr_i[AW-1:2], 2'b00};
              be_d    = lsu_be;
              wdata_d = lsu_wdata;
              state_d = lsu_bad ? S_ERR : S_REQ;
            end else begin
              we_d    = 1'b0;
              addr_d  = {ifu_addr_i[AW-1:2], 2'b00};
              be_d    = '1;
              wdata_d = '0;
              state_d = S_REQ;
            end
          end
        end
        S_REQ: begin
          mem_req_o   = 1'b1;
          mem_we_o    = we_q;
          mem_addr_o  = addr_q;
          mem_be_o    = be_q;
          mem_wdata_o = wdata_q;
          if (owner_lsu_q) lsu_gnt_o = mem_gnt_i;
          else             ifu_gnt_o = mem_gnt_i;
          if (mem_gnt_i) begin
            state_d = S_RESP;
            cnt_d   = '0;
          end
        end
        S_RESP: begin
          if (mem_rvalid_i) begin
            if (owner_lsu_q) begin
              lsu_rvalid_o = 1'b1;
              lsu_rdata_o  = mem_rdata_i;
            end else begin
              ifu_rvalid_o = 1'b1;
              ifu_rdata_o  = mem_rdata_i;
            end
            state_d = S_IDLE;
          end else if ((RESP_TIMEOUT != 0) && (cnt_q == TO_VAL)) begin
            if (owner_lsu_q) begin
              lsu_rvalid_o = 1'b1;
              lsu_err_o    = 1'b1;
            end else begin
              ifu_rvalid_o = 1'b1;
              ifu_err_o    = 1'b1;
            end
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_ERR: begin
          lsu_gnt_o    = 1'b1;
          lsu_rvalid_o = 1'b1;
          lsu_err_o    = 1'b1;
          state_d      = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_lsu_q  <= 1'b0;
      owner_lsu_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_lsu_q  <= last_lsu_d;
      owner_lsu_q <= owner_lsu_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Random and directed rounds of IFU/LSU requests. The driver predicts grant
//   order and memory-side attributes from the arbitration and lane rules; the
//   memory responder predicts each response (data, error, cycle). A monitor
//   pops both expectation queues whenever the DUT presents a grant or response.
module tb_mem_port_arbiter;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_i;
  logic [31:0] ifu_addr_i;
  logic        ifu_gnt_o, ifu_rvalid_o, ifu_err_o;
  logic [31:0] ifu_rdata_o;
  logic        lsu_req_i, lsu_we_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic [1:0]  lsu_size_i;
  logic        lsu_gnt_o, lsu_rvalid_o, lsu_err_o;
  logic [31:0] lsu_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        busy_o;

  mem_port_arbiter #(.AW(32), .RESP_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_i(ifu_req_i), .ifu_addr_i(ifu_addr_i), .ifu_gnt_o(ifu_gnt_o),
    .ifu_rvalid_o(ifu_rvalid_o), .ifu_rdata_o(ifu_rdata_o), .ifu_err_o(ifu_err_o),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_addr_i(lsu_addr_i),
    .lsu_size_i(lsu_size_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o),
    .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o), .lsu_err_o(lsu_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          lsu;
    bit          err;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    bit          err;
    logic [31:0] data;
    int unsigned cyc;
  } resp_t;

  typedef struct {
    bit          ie;
    logic [31:0] ia;
    bit          le;
    bit          we;
    logic [31:0] la;
    logic [1:0]  sz;
    logic [31:0] wd;
  } round_t;

  txn_t  exp_txn[$];
  resp_t exp_resp[$];
  bit    inflight[$];
  bit    last_lsu   = 1'b0;
  bit    stale_mode = 1'b0;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit all_zero();
    return ({ifu_gnt_o, ifu_rvalid_o, ifu_rdata_o, ifu_err_o,
             lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o, lsu_err_o,
             mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, busy_o} == '0);
  endfunction

  function automatic txn_t mk_ifu(input logic [31:0] a);
    txn_t t;
    t.lsu = 1'b0; t.err = 1'b0; t.we = 1'b0;
    t.addr = a & 32'hFFFF_FFFC; t.be = 4'hF; t.wdata = '0;
    return t;
  endfunction

  function automatic txn_t mk_lsu(input bit we, input logic [31:0] a,
                                  input logic [1:0] sz, input logic [31:0] wd);
    txn_t t;
    t.lsu = 1'b1; t.we = we; t.addr = a & 32'hFFFF_FFFC;
    t.be = 4'hF; t.wdata = wd;
    t.err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    if (sz == 2'b00) begin
      t.be    = 4'(1 << a[1:0]);
      t.wdata = {24'h0, wd[7:0]} * 32'h0101_0101;
    end else if (sz == 2'b01) begin
      t.be    = a[1] ? 4'b1100 : 4'b0011;
      t.wdata = {16'h0, wd[15:0]} * 32'h0001_0001;
    end
    return t;
  endfunction

  // Memory responder: random grant delay, random latency 1..3, occasional
  // silent drop (expects a timeout) and spurious rvalid outside a transaction.
  initial begin
    bit          gnt_prev = 1'b0;
    bit          pend = 1'b0;
    bit          drive_due = 1'b0;
    int unsigned due = 0;
    int unsigned g;
    logic [31:0] d = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    forever begin
      @(posedge clk); #1;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = $urandom;
      if (gnt_prev) begin
        pend = 1'b1;
        g = cyc - 1;
        d = $urandom;
        if (stale_mode) begin
          due = g + 2; drive_due = 1'b1;
        end else if ($urandom_range(0, 5) == 0) begin
          due = g + 1 + TO; drive_due = 1'b0;
          exp_resp.push_back('{err: 1'b1, data: 32'h0, cyc: due});
        end else begin
          due = g + $urandom_range(1, 3); drive_due = 1'b1;
          exp_resp.push_back('{err: 1'b0, data: d, cyc: due});
        end
      end
      if (pend) begin
        if (cyc == due) begin
          pend = 1'b0;
          if (drive_due) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = d;
          end
        end
      end else if ($urandom_range(0, 7) == 0) begin
        mem_rvalid_i = 1'b1;
      end
      gnt_prev  = (mem_req_o === 1'b1) && !pend && ($urandom_range(0, 2) != 0);
      mem_gnt_i = gnt_prev;
    end
  end

  // Monitor
  initial begin
    bit    prev_resp = 1'b0;
    bit    prev_idle_req = 1'b0;
    txn_t  t;
    resp_t r;
    bit    o;
    forever begin
      @(negedge clk);
      if (rst) begin
        inflight.delete();
        prev_resp = 1'b0;
        prev_idle_req = 1'b0;
        chk("reset_outputs_zero", 32'(all_zero()), 32'd1);
      end else begin
        if (prev_resp)     chk("busy_gap_after_resp", 32'(busy_o), 32'd0);
        if (prev_idle_req) chk("busy_after_idle_req", 32'(busy_o), 32'd1);
        prev_idle_req = !busy_o && (ifu_req_i || lsu_req_i);

        if (ifu_gnt_o || lsu_gnt_o) begin
          if (exp_txn.size() == 0) begin
            checks++; errors++;
            $display("FAIL gnt_unexpected: ifu_gnt=%b lsu_gnt=%b expected none", ifu_gnt_o, lsu_gnt_o);
          end else begin
            t = exp_txn.pop_front();
            chk("gnt_owner", 32'({ifu_gnt_o, lsu_gnt_o}), t.lsu ? 32'd1 : 32'd2);
            if (t.err) begin
              chk("err_pulse", 32'({lsu_rvalid_o, lsu_err_o, mem_req_o, ifu_rvalid_o}), 32'b1100);
              chk("err_rdata", lsu_rdata_o, 32'h0);
            end else begin
              chk("mem_req_gnt_we", 32'({mem_req_o, mem_gnt_i, mem_we_o}), 32'({2'b11, t.we}));
              chk("mem_addr", mem_addr_o, t.addr);
              chk("mem_be", 32'(mem_be_o), 32'(t.be));
              if (t.we) chk("mem_wdata", mem_wdata_o, t.wdata);
              inflight.push_back(t.lsu);
            end
          end
        end else if (mem_req_o && mem_gnt_i) begin
          checks++; errors++;
          $display("FAIL mem_gnt_without_owner_gnt: got 0 expected 1");
        end

        if (ifu_rvalid_o || (lsu_rvalid_o && !lsu_gnt_o)) begin
          if (exp_resp.size() == 0 || inflight.size() == 0) begin
            checks++; errors++;
            $display("FAIL resp_unexpected: ifu_rvalid=%b lsu_rvalid=%b expected none", ifu_rvalid_o, lsu_rvalid_o);
          end else begin
            r = exp_resp.pop_front();
            o = inflight.pop_front();
            chk("resp_owner", 32'({ifu_rvalid_o, lsu_rvalid_o}), o ? 32'd1 : 32'd2);
            chk("resp_cycle", cyc, r.cyc);
            chk("resp_err", 32'(o ? lsu_err_o : ifu_err_o), 32'(r.err));
            chk("resp_rdata", o ? lsu_rdata_o : ifu_rdata_o, r.data);
          end
        end
        if (!ifu_rvalid_o) chk("ifu_quiet", 32'(ifu_rdata_o == 0 && !ifu_err_o), 32'd1);
        if (!lsu_rvalid_o) chk("lsu_quiet", 32'(lsu_rdata_o == 0 && !lsu_err_o), 32'd1);
        prev_resp = ifu_rvalid_o || lsu_rvalid_o;
      end
    end
  end

  task automatic wait_gnts(input bit ie, input bit le);
    bit ig = !ie;
    bit lg = !le;
    for (int k = 0; k < 200 && !(ig && lg); k++) begin
      @(negedge clk);
      if (ifu_gnt_o) ig = 1'b1;
      if (lsu_gnt_o) lg = 1'b1;
      @(posedge clk); #1;
      if (ig) ifu_req_i = 1'b0;
      if (lg) lsu_req_i = 1'b0;
    end
    if (!(ig && lg)) begin
      checks++; errors++;
      $display("FAIL gnt_timeout: ifu_done=%b lsu_done=%b expected 1 1", ig, lg);
      ifu_req_i = 1'b0; lsu_req_i = 1'b0;
    end
  endtask

  task automatic run_round(input round_t rd);
    txn_t ti, tl;
    bit   done = 1'b0;
    @(posedge clk); #1;
    ti = mk_ifu(rd.ia);
    tl = mk_lsu(rd.we, rd.la, rd.sz, rd.wd);
    if (rd.ie && rd.le) begin
      if (!last_lsu) begin exp_txn.push_back(tl); exp_txn.push_back(ti); last_lsu = 1'b0; end
      else           begin exp_txn.push_back(ti); exp_txn.push_back(tl); last_lsu = 1'b1; end
    end else if (rd.le) begin
      exp_txn.push_back(tl); last_lsu = 1'b1;
    end else begin
      exp_txn.push_back(ti); last_lsu = 1'b0;
    end
    ifu_req_i = rd.ie; ifu_addr_i = rd.ia;
    lsu_req_i = rd.le; lsu_we_i = rd.we; lsu_addr_i = rd.la;
    lsu_size_i = rd.sz; lsu_wdata_i = rd.wd;
    wait_gnts(rd.ie, rd.le);
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      done = (exp_resp.size() == 0) && (inflight.size() == 0) && !busy_o;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL round_drain: got busy=%b pending=%0d expected idle", busy_o, exp_resp.size());
      exp_resp.delete();
    end
  endtask

  round_t dir[$] = '{
    '{ie: 1, ia: 32'h104, le: 0, we: 0, la: 32'h0,   sz: 2'b10, wd: 32'h0},
    '{ie: 1, ia: 32'h400, le: 1, we: 0, la: 32'h500, sz: 2'b10, wd: 32'h0},
    '{ie: 1, ia: 32'h404, le: 1, we: 1, la: 32'h504, sz: 2'b10, wd: 32'hDEAD_BEEF},
    '{ie: 1, ia: 32'h408, le: 1, we: 0, la: 32'h50A, sz: 2'b01, wd: 32'h0},
    '{ie: 0, ia: 32'h0,   le: 1, we: 1, la: 32'h203, sz: 2'b00, wd: 32'h0000_00AB},
    '{ie: 0, ia: 32'h0,   le: 1, we: 1, la: 32'h202, sz: 2'b01, wd: 32'h0000_1234},
    '{ie: 0, ia: 32'h0,   le: 1, we: 0, la: 32'h102, sz: 2'b10, wd: 32'h0},
    '{ie: 0, ia: 32'h0,   le: 1, we: 1, la: 32'h100, sz: 2'b11, wd: 32'h5555_5555},
    '{ie: 1, ia: 32'h40C, le: 1, we: 1, la: 32'h201, sz: 2'b01, wd: 32'h0000_7777}
  };

  initial begin
    round_t rd;
    bit     seen;
    rst = 1'b1;
    ifu_req_i = 1'b0; ifu_addr_i = '0;
    lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_addr_i = '0; lsu_size_i = '0; lsu_wdata_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("after_reset_outputs_zero", 32'(all_zero()), 32'd1);

    foreach (dir[i]) run_round(dir[i]);

    for (int n = 0; n < 250; n++) begin
      rd.ie = $urandom_range(0, 1);
      rd.le = !rd.ie || ($urandom_range(0, 1) == 1);
      rd.ia = $urandom;
      rd.we = $urandom_range(0, 1);
      rd.la = $urandom;
      rd.sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      rd.wd = $urandom;
      run_round(rd);
    end

    // Reset while waiting for a response; the late response must be dropped.
    stale_mode = 1'b1;
    @(posedge clk); #1;
    exp_txn.push_back(mk_ifu(32'h300));
    ifu_req_i = 1'b1; ifu_addr_i = 32'h300;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      seen = ifu_gnt_o;
      if (!seen) begin @(posedge clk); #1; end
    end
    chk("rst_test_gnt_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    ifu_req_i = 1'b0;
    rst = 1'b1;
    last_lsu = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("stale_rvalid_ignored", 32'(all_zero()), 32'd1);
    stale_mode = 1'b0;
    run_round('{ie: 1, ia: 32'h600, le: 1, we: 0, la: 32'h700, sz: 2'b10, wd: 32'h0});

    chk("txn_queue_drained", exp_txn.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
